// File: rtl/matrix_capture_if.sv
// Pin bundle of the 16x16 LED matrix display interface.
// The display driver is the master; the capture monitor is the slave.
interface matrix_capture_if;
   logic RCLK;
   logic RSDI;
   logic CCLK;
   logic CSDI;
   logic LE;
   logic OEB;

   modport master (output RCLK, output RSDI, output CCLK, output CSDI, output LE, output OEB);
   modport slave  (input  RCLK, input  RSDI, input  CCLK, input  CSDI, input  LE, input  OEB);
endinterface

// File: rtl/matrix_capture.sv
// Receive-side model of the 16x16 LED matrix display. Samples the serial
// display pins, deserialises row/column words and commits each latched
// column word into a 16x16 frame buffer that can be read back by row.
module matrix_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAMECNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   matrix_capture_if.slave       pins,
   input  logic [3:0]            rd_row,
   output logic [15:0]           rd_data,
   output logic                  row_commit,
   output logic                  frame_done,
   output logic [FRAMECNT_W-1:0] frame_count,
   output logic                  onehot_err,
   input  logic                  clr_err,
   output logic                  blanked
);

   // Bit positions of the pins inside the packed pin vector.
   localparam int P_RCLK = 0;
   localparam int P_RSDI = 1;
   localparam int P_CCLK = 2;
   localparam int P_CSDI = 3;
   localparam int P_LE   = 4;
   localparam int P_OEB  = 5;

   logic [5:0]  pin_raw;
   logic [5:0]  pin_sync;
   logic [4:0]  prev_reg;        // one stage behind pin_sync, keeps data aligned with strobes
   logic        rclk_rise_reg;
   logic        cclk_rise_reg;
   logic        le_rise_reg;
   logic [15:0] row_sr_reg;
   logic [15:0] col_sr_reg;
   logic [15:0] fb_reg [16];
   logic [15:0] rd_data_reg;
   logic        row_commit_reg;
   logic        frame_done_reg;
   logic [FRAMECNT_W-1:0] frame_count_reg;
   logic        onehot_err_reg;
   logic        row_onehot;

   assign pin_raw = {pins.OEB, pins.LE, pins.CSDI, pins.CCLK, pins.RSDI, pins.RCLK};

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_sync
         // OEB idles high (display blanked), every other pin idles low.
         localparam logic RST_VAL = (gi == P_OEB);
         logic [SYNC_STAGES-1:0] chain_reg;

         // Synchroniser chain for one pin.
         always_ff @(posedge clk) begin
            if (reset) chain_reg <= {SYNC_STAGES{RST_VAL}};
            else       chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
         end

         assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   // Edge detect: registered rise strobes; data pins delayed by the same stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_reg      <= '0;
         rclk_rise_reg <= 1'b0;
         cclk_rise_reg <= 1'b0;
         le_rise_reg   <= 1'b0;
      end else begin
         prev_reg      <= pin_sync[4:0];
         rclk_rise_reg <= pin_sync[P_RCLK] & ~prev_reg[P_RCLK];
         cclk_rise_reg <= pin_sync[P_CCLK] & ~prev_reg[P_CCLK];
         le_rise_reg   <= pin_sync[P_LE]   & ~prev_reg[P_LE];
      end
   end

   // Row and column shift registers; a commit in the same cycle sees the pre-shift values.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_sr_reg <= '0;
         col_sr_reg <= '0;
      end else begin
         if (rclk_rise_reg) row_sr_reg <= {row_sr_reg[14:0], prev_reg[P_RSDI]};
         if (cclk_rise_reg) col_sr_reg <= {col_sr_reg[14:0], prev_reg[P_CSDI]};
      end
   end

   assign row_onehot = (row_sr_reg != 16'd0) && ((row_sr_reg & (row_sr_reg - 16'd1)) == 16'd0);

   generate
      for (gi = 0; gi < 16; gi++) begin : g_fb
         // Frame buffer row: written on commit whenever its row bit is set.
         always_ff @(posedge clk) begin
            if (reset)                             fb_reg[gi] <= '0;
            else if (le_rise_reg && row_sr_reg[gi]) fb_reg[gi] <= col_sr_reg;
         end
      end
   endgenerate

   // Registered read port; a same-cycle write is not forwarded.
   always_ff @(posedge clk) begin
      if (reset) rd_data_reg <= '0;
      else       rd_data_reg <= fb_reg[rd_row];
   end

   // Commit status: pulses, frame counter and sticky one-hot error (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         row_commit_reg  <= 1'b0;
         frame_done_reg  <= 1'b0;
         frame_count_reg <= '0;
         onehot_err_reg  <= 1'b0;
      end else begin
         row_commit_reg <= le_rise_reg;
         frame_done_reg <= le_rise_reg & row_sr_reg[15];
         if (le_rise_reg && row_sr_reg[15])
            frame_count_reg <= frame_count_reg + FRAMECNT_W'(1);
         if (le_rise_reg && !row_onehot)
            onehot_err_reg <= 1'b1;
         else if (clr_err)
            onehot_err_reg <= 1'b0;
      end
   end

   assign rd_data     = rd_data_reg;
   assign row_commit  = row_commit_reg;
   assign frame_done  = frame_done_reg;
   assign frame_count = frame_count_reg;
   assign onehot_err  = onehot_err_reg;
   assign blanked     = pin_sync[P_OEB];

endmodule

// File: tb/tb_matrix_capture.sv
// Directed bench for matrix_capture: pin-level stimulus, a small display
// model and a read-back scoreboard compared on the falling clock edge.
module tb_matrix_capture;
   localparam int SYNC = 2;
   localparam int FCW  = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [3:0]     rd_row = 4'd0;
   logic [15:0]    rd_data;
   logic           row_commit;
   logic           frame_done;
   logic [FCW-1:0] frame_count;
   logic           onehot_err;
   logic           clr_err = 1'b0;
   logic           blanked;

   matrix_capture_if pins_if ();

   matrix_capture #(.SYNC_STAGES(SYNC), .FRAMECNT_W(FCW)) dut (
      .clk         (clk),
      .reset       (reset),
      .pins        (pins_if),
      .rd_row      (rd_row),
      .rd_data     (rd_data),
      .row_commit  (row_commit),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .onehot_err  (onehot_err),
      .clr_err     (clr_err),
      .blanked     (blanked)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Display model
   logic [15:0]    m_fb [16];
   logic [15:0]    m_row;
   logic [15:0]    m_col;
   logic           m_err;
   logic [FCW-1:0] m_fc;
   int             m_commits;
   int             m_frames;
   logic [31:0]    exp_q [$];

   // Pulse monitor
   int   commit_seen = 0;
   int   frame_seen  = 0;
   int   wide_pulses = 0;
   logic rc_prev     = 1'b0;

   always @(negedge clk) begin
      if (row_commit) commit_seen++;
      if (frame_done) frame_seen++;
      if (row_commit && rc_prev) wide_pulses++;
      rc_prev = row_commit;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_fb[i] = '0;
      m_row = '0;
      m_col = '0;
      m_err = 1'b0;
      m_fc  = '0;
   endtask

   task automatic model_commit();
      int ones = 0;
      for (int i = 0; i < 16; i++) begin
         if (m_row[i]) begin
            m_fb[i] = m_col;
            ones++;
         end
      end
      if (ones != 1) m_err = 1'b1;
      if (m_row[15]) begin
         m_fc = m_fc + 1'b1;
         m_frames++;
      end
      m_commits++;
   endtask

   // Expected row content queued at request, compared when rd_data appears.
   task automatic read_row(input int r, input string tag);
      exp_q.push_back({16'd0, m_fb[r]});
      rd_row = 4'(r);
      @(negedge clk);
      check(tag, {16'd0, rd_data}, exp_q.pop_front());
   endtask

   // Shift the top n bits of both words MSB first, row and column clocks together.
   task automatic shift_both(input logic [15:0] r, input logic [15:0] c, input int n);
      for (int i = 15; i > 15 - n; i--) begin
         pins_if.RSDI = r[i];
         pins_if.CSDI = c[i];
         repeat (2) @(negedge clk);
         pins_if.RCLK = 1'b1;
         pins_if.CCLK = 1'b1;
         repeat (2) @(negedge clk);
         pins_if.RCLK = 1'b0;
         pins_if.CCLK = 1'b0;
         m_row = {m_row[14:0], r[i]};
         m_col = {m_col[14:0], c[i]};
      end
      repeat (SYNC + 3) @(negedge clk);
   endtask

   task automatic commit();
      pins_if.LE = 1'b1;
      model_commit();
      repeat (2) @(negedge clk);
      pins_if.LE = 1'b0;
      repeat (SYNC + 4) @(negedge clk);
   endtask

   initial begin
      pins_if.RCLK = 1'b0; pins_if.RSDI = 1'b0; pins_if.CCLK = 1'b0;
      pins_if.CSDI = 1'b0; pins_if.LE   = 1'b0; pins_if.OEB  = 1'b1;
      m_commits = 0;
      m_frames  = 0;
      model_reset();

      // Reset held 3 cycles with pins toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pins_if.RCLK = ~pins_if.RCLK; pins_if.CCLK = ~pins_if.CCLK;
         pins_if.LE   = ~pins_if.LE;   pins_if.OEB  = ~pins_if.OEB;
         pins_if.CSDI = ~pins_if.CSDI; pins_if.RSDI = ~pins_if.RSDI;
      end
      @(negedge clk);
      pins_if.RCLK = 1'b0; pins_if.CCLK = 1'b0; pins_if.LE = 1'b0;
      pins_if.CSDI = 1'b0; pins_if.RSDI = 1'b0; pins_if.OEB = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_row_commit", {31'd0, row_commit}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frame_count", {24'd0, frame_count}, 32'd0);
      check("rst_onehot_err", {31'd0, onehot_err}, 32'd0);
      check("rst_blanked", {31'd0, blanked}, 32'd1);
      for (int r = 0; r < 16; r++) read_row(r, $sformatf("rst_row%0d", r));

      // OEB only drives blanked
      pins_if.OEB = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      check("blanked_low", {31'd0, blanked}, 32'd0);

      // Single row commit (display enabled)
      shift_both(16'h0001, 16'hA5C3, 16);
      commit();
      check("single_commit_cnt", commit_seen, m_commits);
      for (int r = 0; r < 16; r++) read_row(r, $sformatf("single_row%0d", r));
      pins_if.OEB = 1'b1;
      repeat (SYNC + 1) @(negedge clk);
      check("blanked_high", {31'd0, blanked}, 32'd1);

      // Full frame: one-hot rows 0..15, column word row*0x0101
      for (int r = 0; r < 16; r++) begin
         shift_both(16'(1 << r), 16'(r * 16'h0101), 16);
         commit();
      end
      check("frame_count_1", {24'd0, frame_count}, {24'd0, m_fc});
      check("frame_done_cnt", frame_seen, m_frames);
      check("frame_commit_cnt", commit_seen, m_commits);
      check("frame_no_err", {31'd0, onehot_err}, {31'd0, m_err});
      for (int r = 0; r < 16; r++) read_row(r, $sformatf("frame_row%0d", r));

      // Two-row commit: both rows written, sticky error
      shift_both(16'h0003, 16'h3C3C, 16);
      commit();
      check("err_set", {31'd0, onehot_err}, {31'd0, m_err});
      read_row(0, "err_row0");
      read_row(1, "err_row1");
      read_row(2, "err_row2");
      repeat (5) @(negedge clk);
      check("err_sticky", {31'd0, onehot_err}, 32'd1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_err = 1'b0;
      @(negedge clk);
      check("err_cleared", {31'd0, onehot_err}, {31'd0, m_err});

      // clr_err in exactly the commit cycle of another bad commit: set wins
      pins_if.LE = 1'b1;
      model_commit();
      repeat (2) @(negedge clk);
      pins_if.LE = 1'b0;
      repeat (SYNC - 1) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("err_set_wins", {31'd0, onehot_err}, {31'd0, m_err});
      repeat (SYNC + 3) @(negedge clk);
      check("err_set_wins_hold", {31'd0, onehot_err}, 32'd1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_err = 1'b0;

      // Simultaneous CCLK and LE rise: commit sees pre-shift column word
      shift_both(16'h0020, 16'h00FF, 16);
      pins_if.CSDI = 1'b1;
      repeat (2) @(negedge clk);
      pins_if.CCLK = 1'b1;
      pins_if.LE   = 1'b1;
      model_commit();
      m_col = {m_col[14:0], 1'b1};
      repeat (2) @(negedge clk);
      pins_if.CCLK = 1'b0;
      pins_if.LE   = 1'b0;
      repeat (SYNC + 4) @(negedge clk);
      read_row(5, "simul_row5");
      commit();
      read_row(5, "simul_col_after");
      check("simul_commit_cnt", commit_seen, m_commits);

      // Frame counter wrap using repeated commits of row 15
      shift_both(16'h8000, 16'hBEEF, 16);
      while (m_fc != 8'hFF) commit();
      check("fc_255", {24'd0, frame_count}, {24'd0, m_fc});
      commit();
      check("fc_wrap", {24'd0, frame_count}, {24'd0, m_fc});
      check("wrap_frames", frame_seen, m_frames);
      read_row(15, "wrap_row15");

      // Reset in the middle of a partial shift
      shift_both(16'hFFFF, 16'hFFFF, 8);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check("mid_rst_fc", {24'd0, frame_count}, 32'd0);
      shift_both(16'h0004, 16'h1234, 16);
      commit();
      read_row(2, "mid_rst_row2");
      read_row(0, "mid_rst_row0");
      read_row(15, "mid_rst_row15");
      check("mid_rst_err", {31'd0, onehot_err}, {31'd0, m_err});
      check("total_commits", commit_seen, m_commits);
      check("pulse_width", wide_pulses, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
